// File: rtl/interp_coef_seq.sv
// Read-side sequencer for the polyphase interpolation coefficient RAM (port 2).
// Sweeps every phase/tap address in order and streams coefficients over valid/ready.
module interp_coef_seq #(
    parameter int unsigned PHASES = 5,
    parameter int unsigned TAPS   = 8,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic              ram_clken,
    input  logic [DATA_W-1:0] ram_readdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_coef,
    output logic [2:0]        out_phase,
    output logic [2:0]        out_tap,
    output logic              out_last
);

    localparam int unsigned TAP_W      = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned ENTRY_W    = DATA_W + 3 + 3 + 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } state_e;

    state_e state_q, state_d;

    logic [2:0]       phase_q, phase_d;
    logic [TAP_W-1:0] tap_q, tap_d;

    logic             issue;
    logic             issue_last;
    logic [2:0]       credit;
    logic             push;
    logic             pop;

    // One-stage tag register travelling alongside the RAM read.
    logic             rd_pending_q;
    logic [2:0]       tag_phase_q;
    logic [TAP_W-1:0] tag_tap_q;
    logic             tag_last_q;

    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [1:0]         wr_ptr_q;
    logic [1:0]         rd_ptr_q;
    logic [2:0]         occ_q;
    logic [ENTRY_W-1:0] head;

    assign issue_last = (phase_q == 3'(PHASES - 1)) && (tap_q == TAP_W'(TAPS - 1));

    // Reserve FIFO room for the beat about to be issued and the one still in flight.
    assign credit = occ_q + {2'b00, rd_pending_q};
    assign issue  = (state_q == StRun) && !abort && (credit <= 3'd2);

    assign push = rd_pending_q && !abort;
    assign pop  = out_valid && out_ready;

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (start) state_d = StRun;
                StRun:   if (issue && issue_last) state_d = StDrain;
                StDrain: if (pop && out_last) state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        busy           = (state_q != StIdle);
        ram_chipselect = issue;
        ram_address    = ADDR_W'({phase_q, tap_q});
        ram_write      = 1'b0;
        ram_clken      = 1'b1;
        out_valid      = (occ_q != 3'd0);
        out_coef       = '0;
        out_phase      = '0;
        out_tap        = '0;
        out_last       = 1'b0;
        if (out_valid) begin
            out_coef  = head[ENTRY_W-1 -: DATA_W];
            out_phase = head[6:4];
            out_tap   = head[3:1];
            out_last  = head[0];
        end
    end

    // ---------------------------------------------------------------- address counters
    always_comb begin
        phase_d = phase_q;
        tap_d   = tap_q;
        if (state_q == StIdle && start && !abort) begin
            phase_d = '0;
            tap_d   = '0;
        end else if (issue && !issue_last) begin
            tap_d = tap_q + 1'b1;
            if (tap_q == TAP_W'(TAPS - 1)) begin
                phase_d = phase_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= '0;
            tap_q   <= '0;
        end else begin
            phase_q <= phase_d;
            tap_q   <= tap_d;
        end
    end

    // ---------------------------------------------------------------- read tags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pending_q <= 1'b0;
            tag_phase_q  <= '0;
            tag_tap_q    <= '0;
            tag_last_q   <= 1'b0;
        end else begin
            rd_pending_q <= issue;
            if (issue) begin
                tag_phase_q <= phase_q;
                tag_tap_q   <= tap_q;
                tag_last_q  <= issue_last;
            end
        end
    end

    // ---------------------------------------------------------------- output FIFO
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else if (abort) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   occ_q <= occ_q + 1'b1;
                2'b01:   occ_q <= occ_q - 1'b1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    // Storage needs no reset: outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {ram_readdata, tag_phase_q, 3'(tag_tap_q), tag_last_q};
        end
    end

    assign head = fifo_mem[rd_ptr_q];

endmodule

// File: tb/tb_interp_coef_seq.sv
// Self-checking bench for interp_coef_seq: cycle table for start/backpressure timing,
// scoreboard of expected beats, and hand sequences for abort, reset and restart cases.
module tb_interp_coef_seq;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;
    localparam int BEATS  = 40;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              out_ready = 1'b0;
    logic              busy;
    logic [ADDR_W-1:0] ram_address;
    logic              ram_chipselect;
    logic              ram_write;
    logic              ram_clken;
    logic [DATA_W-1:0] ram_readdata;
    logic              out_valid;
    logic [DATA_W-1:0] out_coef;
    logic [2:0]        out_phase;
    logic [2:0]        out_tap;
    logic              out_last;

    interp_coef_seq dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .abort         (abort),
        .busy          (busy),
        .ram_address   (ram_address),
        .ram_chipselect(ram_chipselect),
        .ram_write     (ram_write),
        .ram_clken     (ram_clken),
        .ram_readdata  (ram_readdata),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_coef      (out_coef),
        .out_phase     (out_phase),
        .out_tap       (out_tap),
        .out_last      (out_last)
    );

    always #5 clk = ~clk;

    // RAM port 2: registered address, q valid the cycle after issue.
    logic [DATA_W-1:0] mem [64];
    initial begin
        for (int n = 0; n < 64; n++) mem[n] = 32'hC0DE0000 + 32'(n);
    end
    always @(posedge clk) begin
        if (ram_clken) ram_readdata <= mem[ram_address];
    end

    typedef struct packed {
        logic [31:0] coef;
        logic [2:0]  phase;
        logic [2:0]  tap;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int beats = 0;
    int first_beat_cyc = -1;
    int last_beat_cyc = -1;
    int start_cyc = 0;
    int max_occ = 0;
    logic  mon_stall = 1'b0;
    beat_t held;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(posedge clk) cyc = cyc + 1;

    // Scoreboard / stall monitor, sampled mid-cycle.
    always @(posedge clk) begin
        beat_t cur;
        beat_t e;
        #4;
        cur = '{coef: out_coef, phase: out_phase, tap: out_tap, last: out_last};
        if (reset_n) begin
            if (int'(dut.occ_q) > max_occ) max_occ = int'(dut.occ_q);
            if (mon_stall) check("stall_hold", {out_valid, cur}, {1'b1, held});
            if (out_valid && out_ready && !abort) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual=%0h required=none", cur);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", cur, e);
                end
                beats++;
                if (beats == 1) first_beat_cyc = cyc;
                if (out_last) last_beat_cyc = cyc;
            end
            mon_stall = out_valid && !out_ready && !abort;
            held      = cur;
        end else begin
            mon_stall = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after an edge; the sweep request is driven this cycle.
    task automatic launch();
        beat_t b;
        start          = 1'b1;
        beats          = 0;
        first_beat_cyc = -1;
        last_beat_cyc  = -1;
        start_cyc      = cyc;
        for (int n = 0; n < BEATS; n++) begin
            b.coef  = 32'hC0DE0000 + 32'(n);
            b.phase = 3'(n / 8);
            b.tap   = 3'(n % 8);
            b.last  = (n == BEATS - 1);
            exp_q.push_back(b);
        end
    endtask

    // mode 0: ready=1, mode 1: random ready. action 1: start pulse, 2: abort, 3: async reset,
    // applied once `at_beat` beats have been accepted. Returns in the first cycle busy is low.
    task automatic run(input int mode, input int action, input int at_beat, output int elapsed);
        int  s;
        bit  done;
        s       = cyc;
        done    = 1'b0;
        elapsed = -1;
        for (int n = 0; n < 600; n++) begin
            tick();
            start     = 1'b0;
            abort     = 1'b0;
            out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (!busy) begin
                elapsed = cyc - s;
                return;
            end
            if (!done && action != 0 && beats >= at_beat) begin
                done = 1'b1;
                if (action == 1) begin
                    start = 1'b1;
                end else if (action == 2) begin
                    abort     = 1'b1;
                    out_ready = 1'b1;
                    exp_q.delete();
                    tick();
                    abort = 1'b0;
                    check("abort_next_cycle", {out_valid, busy}, 2'b00);
                    elapsed = cyc - s;
                    return;
                end else if (action == 3) begin
                    #1 reset_n = 1'b0;
                    #1;
                    check("async_reset_outputs",
                          {busy, out_valid, ram_chipselect, ram_address, out_coef, out_phase,
                           out_tap, out_last, ram_write, ram_clken},
                          {3'b000, 6'd0, 32'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1});
                    exp_q.delete();
                    tick();
                    tick();
                    reset_n = 1'b1;
                    return;
                end
            end
        end
        check("sweep_timeout", 64'(busy), 64'd0);
    endtask

    typedef struct {
        logic        start;
        logic        abort;
        logic        ready;
        logic        accept;
        logic        busy;
        logic        cs;
        logic [5:0]  addr;
        logic        valid;
        logic [31:0] coef;
    } row_t;

    function automatic row_t mk(input logic st, input logic ab, input logic rd, input logic acc,
                                input logic bz, input logic cs, input int addr, input logic vl,
                                input int coef_idx);
        row_t r;
        r.start  = st;
        r.abort  = ab;
        r.ready  = rd;
        r.accept = acc;
        r.busy   = bz;
        r.cs     = cs;
        r.addr   = 6'(addr);
        r.valid  = vl;
        r.coef   = 32'hC0DE0000 + 32'(coef_idx);
        return r;
    endfunction

    row_t rows[14];
    int   el;

    initial begin
        rows[0]  = mk(1, 1, 1, 0, 0, 0, 0, 0, 0);  // abort beats start
        rows[1]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 0);
        rows[2]  = mk(1, 0, 1, 1, 0, 0, 0, 0, 0);  // E0 at end of this cycle
        rows[3]  = mk(0, 0, 1, 0, 1, 1, 0, 0, 0);
        rows[4]  = mk(0, 0, 1, 0, 1, 1, 1, 0, 0);
        rows[5]  = mk(0, 0, 1, 0, 1, 1, 2, 1, 0);
        rows[6]  = mk(0, 0, 1, 0, 1, 1, 3, 1, 1);
        rows[7]  = mk(0, 0, 0, 0, 1, 1, 4, 1, 2);
        rows[8]  = mk(0, 0, 0, 0, 1, 0, 0, 1, 2);  // occ 2 + inflight 1: no issue
        rows[9]  = mk(0, 0, 0, 0, 1, 0, 0, 1, 2);
        rows[10] = mk(0, 0, 1, 0, 1, 0, 0, 1, 2);
        rows[11] = mk(0, 0, 1, 0, 1, 1, 5, 1, 3);
        rows[12] = mk(0, 0, 1, 0, 1, 1, 6, 1, 4);
        rows[13] = mk(0, 0, 1, 0, 1, 1, 7, 1, 5);

        tick();
        tick();
        check("reset_values",
              {busy, out_valid, ram_chipselect, ram_address, out_coef, out_phase, out_tap,
               out_last, ram_write, ram_clken},
              {3'b000, 6'd0, 32'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1});
        reset_n = 1'b1;

        // Cycle table: start/abort collision, first-beat latency, backpressure refill.
        for (int i = 0; i < 14; i++) begin
            tick();
            start     = rows[i].start;
            abort     = rows[i].abort;
            out_ready = rows[i].ready;
            if (rows[i].accept) launch();
            #2;
            check($sformatf("row%0d_ctl", i), {busy, ram_chipselect, out_valid},
                  {rows[i].busy, rows[i].cs, rows[i].valid});
            if (rows[i].cs) check($sformatf("row%0d_addr", i), ram_address, rows[i].addr);
            if (rows[i].valid) check($sformatf("row%0d_coef", i), out_coef, rows[i].coef);
        end
        run(0, 0, 0, el);
        check("table_sweep_beats", beats, BEATS);

        // Back-to-back full sweep with ready held high.
        launch();
        run(0, 0, 0, el);
        check("full_first_latency", first_beat_cyc - start_cyc, 3);
        check("full_contiguous", last_beat_cyc - first_beat_cyc, BEATS - 1);
        check("full_busy_fall", el, 43);
        check("full_beats", beats, BEATS);
        check("full_queue_empty", exp_q.size(), 0);

        launch();
        run(1, 0, 0, el);
        check("bp_beats", beats, BEATS);
        check("bp_queue_empty", exp_q.size(), 0);

        launch();
        run(0, 1, 10, el);
        check("start_busy_beats", beats, BEATS);
        for (int n = 0; n < 10; n++) tick();
        check("start_busy_no_second", {busy, 32'(beats)}, {1'b0, 32'(BEATS)});

        launch();
        run(0, 2, 17, el);
        check("abort_beats", beats, 17);
        launch();
        run(0, 0, 0, el);
        check("after_abort_beats", beats, BEATS);
        check("after_abort_busy_fall", el, 43);

        launch();
        run(0, 3, 25, el);
        for (int n = 0; n < 5; n++) tick();
        check("reset_no_resume", {busy, out_valid, 32'(beats)}, {2'b00, 32'd25});
        launch();
        run(0, 0, 0, el);
        check("after_reset_beats", beats, BEATS);
        check("after_reset_queue_empty", exp_q.size(), 0);

        check("occupancy_le_3", 64'(max_occ <= 3), 64'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
